alu_ctrl_pipe: RTL
==================

Name: alu_ctrl_pipe

Overview:
Parametrised successor to the ALU control decoder. It takes the main-control ALU op class and the R-type funct field and produces a registered ALU command, using a valid/ready handshake on both sides. It sits between the decode stage and the ALU. It adds funct-field decoding, back-pressure, multi-cycle (MUL) occupancy tracking and illegal-op flagging.

Parameters:
OP_W, 4, width of op class input
CMD_W, 4, width of ctrl_command output
MUL_LAT, 3, ALU cycles a MUL occupies (>=1); in_ready held low for MUL_LAT-1 cycles after a MUL issues

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous reset, active-high
in_valid  in  1  op_class/funct valid
in_ready  out  1  block can accept an op this cycle
op_class  in  OP_W  0 ADD, 1 SUB, 2 MUL, 3 AND, 4 OR, 5 RTYPE (decode funct); others are illegal
funct  in  6  MIPS funct field, used only when op_class==5
out_valid  out  1  ctrl_command valid
out_ready  in  1  ALU accepts command
ctrl_command  out  CMD_W  0 ADD, 1 SUB, 2 MUL, 3 AND, 4 OR, 5 XOR, 6 NOR, 7 SLT, 8 SLL, 9 SRL
illegal  out  1  qualifies the current out_valid command: op/funct was unrecognised
busy  out  1  MUL occupancy counter nonzero

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, out_valid=0, ctrl_command=0 (ADD), illegal=0, busy=0, occupancy counter=0. Reset overrides any in-flight handshake or MUL count. in_ready=0 during the reset cycle.
- Funct decode (op_class==5):
  - 0x20→ADD, 0x22→SUB, 0x18→MUL, 0x24→AND, 0x25→OR
  - 0x26→XOR, 0x27→NOR, 0x2A→SLT, 0x00→SLL, 0x02→SRL
  - any other value→ADD with illegal=1
- op_class 6..2^OP_W-1 → ADD with illegal=1.
- Commands are zero-extended to CMD_W. CMD_W<4 is unsupported; flag it with an elaboration-time check.
- Latency: an op accepted at posedge N (in_valid & in_ready) appears on out_valid/ctrl_command after posedge N, i.e. 1 cycle.
- States:
  - IDLE: in_ready=1. On accept → FULL.
  - FULL: out_valid=1.
    - in_ready = out_ready & ~busy-gating (pass-through: accept a new op in the same cycle the current one drains).
    - On out_ready & ~new-accept → IDLE.
    - On out_ready with new accept → stay FULL with the new command.
    - If the draining command is MUL and MUL_LAT>1 → MULWAIT (no new accept that cycle).
  - MULWAIT: in_ready=0, out_valid=0, busy=1. Counter is loaded with MUL_LAT-1 on MUL drain and decrements each cycle. When the counter reaches 0 → IDLE, with in_ready=1 the next cycle.
- If MUL_LAT==1, MULWAIT is never entered.
- Output stability: while out_valid=1 & out_ready=0, ctrl_command and illegal hold constant.
- Inputs are ignored when in_valid=0 or in_ready=0.
- funct is a don't-care for non-RTYPE ops; it must not affect the output.

Optional Feature:
ALU_CTRL_PIPE_STATS_EN:
- Defined: adds two outputs, issued_cnt[15:0] and illegal_cnt[15:0].
  - issued_cnt increments on each output handshake (out_valid & out_ready).
  - illegal_cnt increments on each output handshake with illegal=1.
  - Both wrap at 16'hFFFF→0 and clear on rst.
- Undefined: these ports and registers do not exist. Core behaviour is identical either way.

Test Plan:
1. Reset, then op_class=1 with in_valid=1 and out_ready=1 held → out_valid=1 the next cycle, ctrl_command=1, illegal=0; with back-to-back ops ADD, AND, OR, in_ready stays 1 and outputs are 0, 3, 4 on consecutive cycles.
2. Sweep op_class=5 over funct 0x20, 0x22, 0x18, 0x24, 0x25, 0x26, 0x27, 0x2A, 0x00, 0x02 → commands 0, 1, 2, 3, 4, 5, 6, 7, 8, 9; funct=0x3F → command 0 with illegal=1; op_class=9 → command 0 with illegal=1.
3. Back-pressure: issue SUB with out_ready=0 for 4 cycles → out_valid=1, ctrl_command=1 held stable, in_ready=0; raise out_ready while in_valid carries OR → SUB drains, OR appears the next cycle.
4. MUL with MUL_LAT=3: op_class=2 accepted, drained at cycle N → busy=1 and in_ready=0 for cycles N+1 and N+2; in_ready=1 at N+3; a queued ADD is accepted at N+3.
5. Assert rst during MULWAIT (counter=1) and during FULL with out_ready=0 → the next cycle shows out_valid=0, busy=0, ctrl_command=0, and in_ready=1 the cycle after rst deasserts.
6. With ALU_CTRL_PIPE_STATS_EN: issue 5 legal and 2 illegal ops → issued_cnt=7, illegal_cnt=2; preload to 16'hFFFF and issue 1 op → issued_cnt wraps to 0.

Source files
------------

// File: rtl/alu_ctrl_pipe_if.sv
// Valid/ready bundle between decode, alu_ctrl_pipe and the ALU.
// ALU_CTRL_PIPE_STATS_EN adds the issued/illegal counters.
interface alu_ctrl_pipe_if #(
    parameter int OP_W  = 4,
    parameter int CMD_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [OP_W-1:0]  op_class;
    logic [5:0]       funct;
    logic             out_valid;
    logic             out_ready;
    logic [CMD_W-1:0] ctrl_command;
    logic             illegal;
    logic             busy;
`ifdef ALU_CTRL_PIPE_STATS_EN
    logic [15:0]      issued_cnt;
    logic [15:0]      illegal_cnt;

    modport master (
        output in_valid, op_class, funct, out_ready,
        input  in_ready, out_valid, ctrl_command, illegal, busy,
        input  issued_cnt, illegal_cnt
    );
    modport slave (
        input  in_valid, op_class, funct, out_ready,
        output in_ready, out_valid, ctrl_command, illegal, busy,
        output issued_cnt, illegal_cnt
    );
`else
    modport master (
        output in_valid, op_class, funct, out_ready,
        input  in_ready, out_valid, ctrl_command, illegal, busy
    );
    modport slave (
        input  in_valid, op_class, funct, out_ready,
        output in_ready, out_valid, ctrl_command, illegal, busy
    );
`endif
endinterface

// File: rtl/alu_ctrl_pipe.sv
// Registered ALU control decoder with handshake, MUL occupancy and illegal flag.
// Optional ALU_CTRL_PIPE_STATS_EN adds issued/illegal handshake counters.
module alu_ctrl_pipe #(
    parameter int OP_W    = 4,
    parameter int CMD_W   = 4,
    parameter int MUL_LAT = 3
) (
    input logic            clk,
    input logic            rst,
    alu_ctrl_pipe_if.slave bus
);
    localparam int CNT_W    = $clog2(MUL_LAT + 1);
    localparam bit MUL_GATE = (MUL_LAT > 1);

    if (CMD_W < 4) begin : g_cmd_w_chk
        $error("alu_ctrl_pipe: CMD_W must be at least 4");
    end
    if (MUL_LAT < 1) begin : g_lat_chk
        $error("alu_ctrl_pipe: MUL_LAT must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, FULL, MULWAIT} state_t;

    state_t           state_q;
    logic             out_valid_q;
    logic [CMD_W-1:0] cmd_q;
    logic             illegal_q;
    logic             busy_q;
    logic [CNT_W-1:0] cnt_q;

    logic [3:0]       cmd4_d;
    logic [CMD_W-1:0] cmd_d;
    logic             illegal_d;
    logic             in_ready;
    logic             accept;
    logic             mul_hold;

    function automatic logic [4:0] decode(
        input logic [OP_W-1:0] op,
        input logic [5:0]      f
    );
        logic [3:0] c;
        logic       bad;
        c   = 4'd0;
        bad = 1'b0;
        unique case (1'b1)
            op == OP_W'(0): c = 4'd0;
            op == OP_W'(1): c = 4'd1;
            op == OP_W'(2): c = 4'd2;
            op == OP_W'(3): c = 4'd3;
            op == OP_W'(4): c = 4'd4;
            op == OP_W'(5): begin
                unique case (f)
                    6'h20: c = 4'd0;
                    6'h22: c = 4'd1;
                    6'h18: c = 4'd2;
                    6'h24: c = 4'd3;
                    6'h25: c = 4'd4;
                    6'h26: c = 4'd5;
                    6'h27: c = 4'd6;
                    6'h2A: c = 4'd7;
                    6'h00: c = 4'd8;
                    6'h02: c = 4'd9;
                    default: bad = 1'b1;
                endcase
            end
            default: bad = 1'b1;
        endcase
        return {bad, c};
    endfunction

    assign {illegal_d, cmd4_d} = decode(bus.op_class, bus.funct);
    assign cmd_d = CMD_W'(cmd4_d);

    // A draining MUL blocks pass-through so the ALU sees its occupancy.
    assign mul_hold = MUL_GATE && (cmd_q == CMD_W'(4'd2));

    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            unique case (state_q)
                IDLE:    in_ready = 1'b1;
                FULL:    in_ready = bus.out_ready & ~mul_hold;
                default: in_ready = 1'b0;
            endcase
        end
    end

    assign accept = bus.in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            cmd_q       <= '0;
            illegal_q   <= 1'b0;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q     <= FULL;
                        out_valid_q <= 1'b1;
                        cmd_q       <= cmd_d;
                        illegal_q   <= illegal_d;
                    end
                end
                FULL: begin
                    if (bus.out_ready) begin
                        if (accept) begin
                            cmd_q     <= cmd_d;
                            illegal_q <= illegal_d;
                        end else if (mul_hold) begin
                            state_q     <= MULWAIT;
                            out_valid_q <= 1'b0;
                            busy_q      <= 1'b1;
                            cnt_q       <= CNT_W'(MUL_LAT - 1);
                        end else begin
                            state_q     <= IDLE;
                            out_valid_q <= 1'b0;
                        end
                    end
                end
                MULWAIT: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = out_valid_q;
    assign bus.ctrl_command = cmd_q;
    assign bus.illegal      = illegal_q;
    assign bus.busy         = busy_q;

`ifdef ALU_CTRL_PIPE_STATS_EN
    logic [15:0] issued_q;
    logic [15:0] ill_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            issued_q  <= '0;
            ill_cnt_q <= '0;
        end else if (out_valid_q & bus.out_ready) begin
            issued_q <= issued_q + 16'd1;
            if (illegal_q) begin
                ill_cnt_q <= ill_cnt_q + 16'd1;
            end
        end
    end

    assign bus.issued_cnt  = issued_q;
    assign bus.illegal_cnt = ill_cnt_q;
`endif
endmodule
